alu_seq_ctrl: RTL

- Request/response sequencer in front of the 16-bit ALU (18 ops, codes 0-17).
- Accepts one operation at a time and drives the ALU op/operand inputs from registered copies.
- Handles single-cycle ops directly. For DIV/MOD/MUL it issues a one-cycle start pulse and waits for the matching done.
- Returns result, high result and flags with a valid/ready handshake, and keeps a persistent ZNCV status register for the core.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_timeout_cnt.sv | 30 +++
 rtl/alu_seq_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op codes, sequencer state encoding and ZNCV flag layout for the
// ALU request/response sequencer.
package alu_pkg;

  localparam logic [4:0] OP_AND = 5'd0;
  localparam logic [4:0] OP_OR  = 5'd1;
  localparam logic [4:0] OP_DIV = 5'd2;
  localparam logic [4:0] OP_XOR = 5'd3;
  localparam logic [4:0] OP_NOT = 5'd4;
  localparam logic [4:0] OP_MOD = 5'd5;
  localparam logic [4:0] OP_SHL = 5'd6;
  localparam logic [4:0] OP_MUL = 5'd7;
  localparam logic [4:0] OP_SHR = 5'd8;
  localparam logic [4:0] OP_ROL = 5'd9;
  localparam logic [4:0] OP_ADD = 5'd10;
  localparam logic [4:0] OP_SUB = 5'd11;
  localparam logic [4:0] OP_INC = 5'd12;
  localparam logic [4:0] OP_DEC = 5'd13;
  localparam logic [4:0] OP_NEG = 5'd14;
  localparam logic [4:0] OP_TST = 5'd15;
  localparam logic [4:0] OP_MOV = 5'd16;
  localparam logic [4:0] OP_CMP = 5'd17;
  localparam logic [4:0] OP_MAX = OP_CMP;

  // Bit positions inside a {Z,N,C,V} flag nibble.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  function automatic logic is_multi_cycle(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_MOD) || (op == OP_MUL);
  endfunction

  function automatic logic is_illegal(input logic [4:0] op);
    return op > OP_MAX;
  endfunction

  function automatic logic is_div_zero(input logic [4:0] op, input logic [15:0] b);
    return ((op == OP_DIV) || (op == OP_MOD)) && (b == 16'h0000);
  endfunction

endpackage

// File: rtl/alu_timeout_cnt.sv
// Watchdog counter for multi-cycle ALU ops: cleared on start, counts while
// enabled, flags expiry once it has sat at TIMEOUT_CYCLES-1.
module alu_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // NOTE: sequential state is always updated with <= so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Request/response sequencer in front of the 16-bit ALU: runs one op at a
// time, handshakes multi-cycle units and keeps a persistent ZNCV register.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [15:0] rsp_result_high,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [3:0]  status_flags,
  output logic [4:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_start,
  output logic        alu_clr,
  input  logic [15:0] alu_result,
  input  logic [15:0] alu_result_high,
  input  logic        alu_done_div,
  input  logic        alu_done_mod,
  input  logic        alu_done_mul,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_c,
  input  logic        alu_v
);

  state_e     state_q, state_d;
  logic       accept;
  logic       req_is_err;
  logic       done_match;
  logic       timed_out;
  logic       capture;
  logic       load_err;
  logic       abort;
  logic       cnt_clr;
  logic       cnt_en;
  logic [3:0] alu_flags;

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_start = (state_q == ST_START);
  assign accept    = req_valid && req_ready;

  // Errors detectable at accept time skip the ALU entirely.
  assign req_is_err = is_illegal(req_op) || is_div_zero(req_op, req_b);

  // Only the done of the unit that was actually started counts.
  assign done_match = ((alu_op == OP_DIV) && alu_done_div) ||
                      ((alu_op == OP_MOD) && alu_done_mod) ||
                      ((alu_op == OP_MUL) && alu_done_mul);

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_Z] = alu_z;
    alu_flags[FLAG_N] = alu_n;
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  alu_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (timed_out)
  );

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    load_err = 1'b0;
    abort    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_is_err) begin
            load_err = 1'b1;
            state_d  = ST_RESP;
          end else if (is_multi_cycle(req_op)) begin
            state_d = ST_START;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_START: begin
        cnt_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_match) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end else if (timed_out) begin
          load_err = 1'b1;
          abort    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand registers, response capture and the persistent status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_op          <= '0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_clr         <= 1'b0;
      rsp_result      <= '0;
      rsp_result_high <= '0;
      rsp_flags       <= '0;
      rsp_err         <= 1'b0;
      status_flags    <= '0;
    end else begin
      alu_clr <= abort;
      if (accept) begin
        alu_op <= req_op;
        alu_a  <= req_a;
        alu_b  <= req_b;
      end
      if (capture) begin
        // TST and CMP exist only for their flags.
        rsp_result      <= ((alu_op == OP_TST) || (alu_op == OP_CMP)) ? 16'h0000 : alu_result;
        rsp_result_high <= (alu_op == OP_MUL) ? alu_result_high : 16'h0000;
        rsp_flags       <= alu_flags;
        rsp_err         <= 1'b0;
        status_flags    <= alu_flags;
      end else if (load_err) begin
        rsp_result      <= '0;
        rsp_result_high <= '0;
        rsp_flags       <= '0;
        rsp_err         <= 1'b1;
      end
    end
  end

endmodule
